// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the RegFile write-port arbiter slice.
//   DEFAULT_SEL_WIDTH / DEFAULT_DATA_WIDTH : parameter defaults
//   ZERO_REG  : hardwired-zero register index (writes to it are dropped)
//   req_id_e  : requester index (REQ_ALU = 0, REQ_MEM = 1)
//   age_e     : which hold buffer was loaded first when both are valid
package regfile_write_arbiter_pkg;

  localparam int unsigned DEFAULT_SEL_WIDTH  = 5;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned ZERO_REG           = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  // AGE_NONE also covers "both loaded on the same edge".
  typedef enum logic [1:0] {
    AGE_NONE      = 2'd0,
    AGE_ALU_OLDER = 2'd1,
    AGE_MEM_OLDER = 2'd2
  } age_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the arbiter's requester handshakes, RegFile write port and
// hazard-lookup signals.
//   master : writeback stages / decode side (drives requests and queries)
//   slave  : the arbiter
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned SEL_WIDTH  = DEFAULT_SEL_WIDTH
);
  logic                  req0_valid;
  logic [SEL_WIDTH-1:0]  req0_sel;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [SEL_WIDTH-1:0]  req1_sel;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  write;
  logic [SEL_WIDTH-1:0]  write_sel;
  logic [DATA_WIDTH-1:0] write_data;
  logic [SEL_WIDTH-1:0]  rs1_sel;
  logic [SEL_WIDTH-1:0]  rs2_sel;
  logic                  rs1_pending;
  logic                  rs2_pending;

  modport master (
    output req0_valid, req0_sel, req0_data, input req0_ready,
    output req1_valid, req1_sel, req1_data, input req1_ready,
    input  write, write_sel, write_data,
    output rs1_sel, rs2_sel, input rs1_pending, rs2_pending
  );

  modport slave (
    input  req0_valid, req0_sel, req0_data, output req0_ready,
    input  req1_valid, req1_sel, req1_data, output req1_ready,
    output write, write_sel, write_data,
    input  rs1_sel, rs2_sel, output rs1_pending, rs2_pending
  );
endinterface

// File: rtl/regfile_write_arbiter_hold.sv
// wb_hold_buffer: single-entry writeback holding register.
//   load/load_sel/load_data : capture a new entry (load wins over clear)
//   clear                   : entry drained to the write port
//   valid/sel/data          : current contents
//   query_a/b_sel, match_a/b: entry is valid and targets the queried register
module wb_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned SEL_WIDTH  = DEFAULT_SEL_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [SEL_WIDTH-1:0]  load_sel,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [SEL_WIDTH-1:0]  query_a_sel,
  input  logic [SEL_WIDTH-1:0]  query_b_sel,
  output logic                  valid,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  match_a,
  output logic                  match_b
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      sel   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      sel   <= load_sel;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign match_a = valid && (sel == query_a_sel);
  assign match_b = valid && (sel == query_b_sel);
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the RegFile write port between ALU writeback
// (requester 0) and load writeback (requester 1).
//   clock, reset (async, active low)
//   bus.req0_* / bus.req1_*      : valid/ready handshakes into one-entry buffers
//   bus.write / write_sel / data : registered RegFile write port
//   bus.rs1/rs2_sel -> _pending  : RAW lookup against uncommitted writes
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned SEL_WIDTH  = DEFAULT_SEL_WIDTH
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam logic [SEL_WIDTH-1:0] ZERO_SEL = SEL_WIDTH'(ZERO_REG);

  logic                  h0_valid, h1_valid;
  logic [SEL_WIDTH-1:0]  h0_sel, h1_sel;
  logic [DATA_WIDTH-1:0] h0_data, h1_data;
  logic                  h0_match1, h0_match2, h1_match1, h1_match2;
  logic                  grant0, grant1, ready0, ready1, load0, load1;
  req_id_e               rr_ptr;
  age_e                  age_q, age_next;
  logic                  write_q;
  logic [SEL_WIDTH-1:0]  write_sel_q;
  logic [DATA_WIDTH-1:0] write_data_q;

  wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_hold0 (
    .clock(clock), .reset(reset), .load(load0), .clear(grant0),
    .load_sel(bus.req0_sel), .load_data(bus.req0_data),
    .query_a_sel(bus.rs1_sel), .query_b_sel(bus.rs2_sel),
    .valid(h0_valid), .sel(h0_sel), .data(h0_data),
    .match_a(h0_match1), .match_b(h0_match2)
  );

  wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_hold1 (
    .clock(clock), .reset(reset), .load(load1), .clear(grant1),
    .load_sel(bus.req1_sel), .load_data(bus.req1_data),
    .query_a_sel(bus.rs1_sel), .query_b_sel(bus.rs2_sel),
    .valid(h1_valid), .sel(h1_sel), .data(h1_data),
    .match_a(h1_match1), .match_b(h1_match2)
  );

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (h0_valid && h1_valid) begin
      if (h0_sel == h1_sel) begin
        // Same destination: older entry commits first so the younger value
        // survives. Same-edge loads (AGE_NONE) let requester 1 go first.
        if (age_q == AGE_ALU_OLDER) grant0 = 1'b1;
        else                        grant1 = 1'b1;
      end else if (rr_ptr == REQ_ALU) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = h0_valid;
      grant1 = h1_valid;
    end
  end

  assign ready0 = !h0_valid || grant0;
  assign ready1 = !h1_valid || grant1;
  // Writes to the zero register complete the handshake but are dropped.
  assign load0  = bus.req0_valid && ready0 && (bus.req0_sel != ZERO_SEL);
  assign load1  = bus.req1_valid && ready1 && (bus.req1_sel != ZERO_SEL);

  always_comb begin
    age_next = age_q;
    // A load implies its own buffer is free or draining, so only the other
    // buffer's survival decides whether an ordering exists.
    if (load0 && h1_valid && !grant1)      age_next = AGE_MEM_OLDER;
    else if (load1 && h0_valid && !grant0) age_next = AGE_ALU_OLDER;
    else if (grant0 || grant1)             age_next = AGE_NONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= REQ_ALU;
      age_q        <= AGE_NONE;
      write_q      <= 1'b0;
      write_sel_q  <= '0;
      write_data_q <= '0;
    end else begin
      age_q   <= age_next;
      write_q <= grant0 || grant1;
      if (grant0) begin
        rr_ptr       <= REQ_MEM;
        write_sel_q  <= h0_sel;
        write_data_q <= h0_data;
      end else if (grant1) begin
        rr_ptr       <= REQ_ALU;
        write_sel_q  <= h1_sel;
        write_data_q <= h1_data;
      end
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.write       = write_q;
  assign bus.write_sel   = write_sel_q;
  assign bus.write_data  = write_data_q;
  assign bus.rs1_pending = (bus.rs1_sel != ZERO_SEL) &&
                           (h0_match1 || h1_match1 || (write_q && write_sel_q == bus.rs1_sel));
  assign bus.rs2_pending = (bus.rs2_sel != ZERO_SEL) &&
                           (h0_match2 || h1_match2 || (write_q && write_sel_q == bus.rs2_sel));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level model (entries with load sequence
// numbers, a "preferred requester" after each grant, and a RegFile array).
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit            m_v[2];
  logic [SW-1:0] m_sel[2];
  logic [DW-1:0] m_data[2];
  int            m_seq[2];
  int            m_seqctr;
  int            m_pref;
  bit            m_write;
  logic [SW-1:0] m_wsel;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rf[32];
  logic [DW-1:0] dut_rf[32];
  bit            last_acc[2];

  function automatic int model_grant();
    if (m_v[0] && m_v[1]) begin
      if (m_sel[0] == m_sel[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      return m_pref;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic bit model_ready(input int n);
    return !m_v[n] || (model_grant() == n);
  endfunction

  function automatic bit model_pending(input logic [SW-1:0] rs);
    if (rs == '0) return 1'b0;
    return (m_v[0] && m_sel[0] == rs) || (m_v[1] && m_sel[1] == rs) ||
           (m_write && m_wsel == rs);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_v[n] = 1'b0; m_sel[n] = '0; m_data[n] = '0; m_seq[n] = 0; last_acc[n] = 1'b0;
    end
    m_seqctr = 0; m_pref = 0; m_write = 1'b0; m_wsel = '0; m_wdata = '0;
  endtask

  // One clock: RegFile arrays commit what is on the write port, model steps,
  // then time moves to 1 unit past the edge.
  task automatic advance();
    int            g;
    bit            acc[2];
    bit            rv[2];
    logic [SW-1:0] s[2];
    logic [DW-1:0] d[2];
    rv[0] = bus.req0_valid; s[0] = bus.req0_sel; d[0] = bus.req0_data;
    rv[1] = bus.req1_valid; s[1] = bus.req1_sel; d[1] = bus.req1_data;
    g      = model_grant();
    acc[0] = rv[0] && model_ready(0);
    acc[1] = rv[1] && model_ready(1);
    if (bus.write && bus.write_sel != '0) dut_rf[bus.write_sel] = bus.write_data;
    if (m_write && m_wsel != '0) m_rf[m_wsel] = m_wdata;
    if (g >= 0) begin
      m_write = 1'b1; m_wsel = m_sel[g]; m_wdata = m_data[g];
      m_v[g] = 1'b0; m_pref = 1 - g;
    end else begin
      m_write = 1'b0;
    end
    m_seqctr++;
    for (int n = 0; n < 2; n++) begin
      last_acc[n] = acc[n];
      if (acc[n] && s[n] != '0) begin
        m_v[n] = 1'b1; m_sel[n] = s[n]; m_data[n] = d[n]; m_seq[n] = m_seqctr;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [SW-1:0] s0, input logic [DW-1:0] d0,
                       input bit v1, input logic [SW-1:0] s1, input logic [DW-1:0] d1);
    bus.req0_valid = v0; bus.req0_sel = s0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_sel = s1; bus.req1_data = d1;
    #1;
  endtask

  task automatic test_reset();
    drive(0, '0, '0, 0, '0, '0);
    bus.rs1_sel = 5'd3; bus.rs2_sel = 5'd0;
    #6;
    vectors++; if (bus.write !== 1'b0) begin miscompares++; $display("FAIL reset_write: got %b expected 0", bus.write); end
    vectors++; if (bus.write_sel !== 5'd0) begin miscompares++; $display("FAIL reset_write_sel: got %0h expected 0", bus.write_sel); end
    vectors++; if (bus.write_data !== 32'd0) begin miscompares++; $display("FAIL reset_write_data: got %0h expected 0", bus.write_data); end
    vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin miscompares++; $display("FAIL reset_ready: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
    vectors++; if (bus.rs1_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b expected 0", bus.rs1_pending); end
    reset = 1'b1;
    model_reset();
    advance();
    vectors++; if (bus.write !== 1'b0) begin miscompares++; $display("FAIL reset_idle_write: got %b expected 0", bus.write); end
  endtask

  task automatic test_single();
    bus.rs1_sel = 5'd1; bus.rs2_sel = 5'd0;
    drive(1, 5'd1, 32'h2, 0, '0, '0);
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b expected 1", bus.req0_ready); end
    advance();
    drive(0, '0, '0, 0, '0, '0);
    vectors++; if (bus.write !== 1'b0) begin miscompares++; $display("FAIL single_early_write: got %b expected 0", bus.write); end
    vectors++; if (bus.rs1_pending !== 1'b1) begin miscompares++; $display("FAIL single_pending_buf: got %b expected 1", bus.rs1_pending); end
    advance();
    vectors++; if ({bus.write, bus.write_sel, bus.write_data} !== {1'b1, 5'd1, 32'h2}) begin
      miscompares++; $display("FAIL single_port: got w=%b sel=%0h data=%0h expected w=1 sel=1 data=2", bus.write, bus.write_sel, bus.write_data); end
    advance();
    vectors++; if (dut_rf[1] !== 32'h2) begin miscompares++; $display("FAIL single_rf_r1: got %0h expected 2", dut_rf[1]); end
    vectors++; if (bus.write !== 1'b0) begin miscompares++; $display("FAIL single_write_drop: got %b expected 0", bus.write); end
  endtask

  task automatic test_reg0();
    bus.rs1_sel = 5'd0; bus.rs2_sel = 5'd0;
    drive(0, '0, '0, 1, 5'd0, 32'h7);
    vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("FAIL reg0_ready: got %b expected 1", bus.req1_ready); end
    advance();
    drive(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (bus.write !== 1'b0) begin miscompares++; $display("FAIL reg0_no_write: got %b expected 0", bus.write); end
      vectors++; if (bus.rs1_pending !== 1'b0) begin miscompares++; $display("FAIL reg0_pending: got %b expected 0", bus.rs1_pending); end
      advance();
    end
  endtask

  task automatic test_same_reg();
    drive(1, 5'd5, 32'hA, 1, 5'd5, 32'hB);
    vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin miscompares++; $display("FAIL same_ready: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
    advance();
    drive(0, '0, '0, 0, '0, '0);
    advance();
    vectors++; if ({bus.write, bus.write_sel, bus.write_data} !== {1'b1, 5'd5, 32'hB}) begin
      miscompares++; $display("FAIL same_first: got w=%b sel=%0h data=%0h expected w=1 sel=5 data=b", bus.write, bus.write_sel, bus.write_data); end
    advance();
    vectors++; if ({bus.write, bus.write_sel, bus.write_data} !== {1'b1, 5'd5, 32'hA}) begin
      miscompares++; $display("FAIL same_second: got w=%b sel=%0h data=%0h expected w=1 sel=5 data=a", bus.write, bus.write_sel, bus.write_data); end
    advance();
    vectors++; if (dut_rf[5] !== 32'hA) begin miscompares++; $display("FAIL same_final_r5: got %0h expected a", dut_rf[5]); end
  endtask

  task automatic test_hazard();
    bus.rs1_sel = 5'd5; bus.rs2_sel = 5'd7;
    drive(1, 5'd5, 32'h55, 0, '0, '0);
    vectors++; if (bus.rs1_pending !== 1'b0) begin miscompares++; $display("FAIL hazard_before: got %b expected 0", bus.rs1_pending); end
    advance();
    drive(0, '0, '0, 0, '0, '0);
    vectors++; if ({bus.rs1_pending, bus.rs2_pending} !== 2'b10) begin miscompares++; $display("FAIL hazard_buffered: got %b expected 10", {bus.rs1_pending, bus.rs2_pending}); end
    advance();
    vectors++; if ({bus.write, bus.rs1_pending} !== 2'b11) begin miscompares++; $display("FAIL hazard_on_port: got %b expected 11", {bus.write, bus.rs1_pending}); end
    advance();
    vectors++; if (bus.rs1_pending !== 1'b0) begin miscompares++; $display("FAIL hazard_after: got %b expected 0", bus.rs1_pending); end
  endtask

  task automatic test_contention();
    logic [SW-1:0] prev;
    prev = '0;
    bus.rs1_sel = 5'd3; bus.rs2_sel = 5'd7;
    drive(1, 5'd3, 32'h5, 1, 5'd7, 32'h9);
    for (int i = 0; i < 12; i++) begin
      advance();
      if (i >= 1) begin
        vectors++; if (bus.write !== 1'b1) begin miscompares++; $display("FAIL contention_bubble: cycle %0d got %b expected 1", i, bus.write); end
        vectors++; if ({bus.write_sel, bus.write_data} !== {m_wsel, m_wdata}) begin
          miscompares++; $display("FAIL contention_port: cycle %0d got sel=%0h data=%0h expected sel=%0h data=%0h", i, bus.write_sel, bus.write_data, m_wsel, m_wdata); end
        if (i >= 2) begin
          vectors++; if (bus.write_sel === prev) begin miscompares++; $display("FAIL contention_alternate: cycle %0d got sel=%0h twice, expected alternation", i, bus.write_sel); end
        end
        prev = bus.write_sel;
      end
    end
  endtask

  // Runs with both buffers full and both requesters still streaming.
  task automatic test_reset_midstream();
    reset = 1'b0;
    #1;
    vectors++; if ({bus.write, bus.write_sel} !== 6'd0) begin miscompares++; $display("FAIL midreset_port: got w=%b sel=%0h expected w=0 sel=0", bus.write, bus.write_sel); end
    vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin miscompares++; $display("FAIL midreset_ready: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
    vectors++; if ({bus.rs1_pending, bus.rs2_pending} !== 2'b00) begin miscompares++; $display("FAIL midreset_pending: got %b expected 00", {bus.rs1_pending, bus.rs2_pending}); end
    drive(0, '0, '0, 0, '0, '0);
    @(posedge clock);
    #1;
    vectors++; if (bus.write !== 1'b0) begin miscompares++; $display("FAIL midreset_held: got %b expected 0", bus.write); end
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_random();
    logic [41:0] act, exp;
    for (int i = 0; i < 600; i++) begin
      if (!(bus.req0_valid && !last_acc[0])) begin
        bus.req0_valid = ($urandom_range(0, 9) < 6);
        bus.req0_sel   = SW'($urandom_range(0, 7));
        bus.req0_data  = $urandom();
      end
      if (!(bus.req1_valid && !last_acc[1])) begin
        bus.req1_valid = ($urandom_range(0, 9) < 6);
        bus.req1_sel   = SW'($urandom_range(0, 7));
        bus.req1_data  = $urandom();
      end
      bus.rs1_sel = SW'($urandom_range(0, 7));
      bus.rs2_sel = SW'($urandom_range(0, 7));
      #1;
      act = {bus.req0_ready, bus.req1_ready, bus.write, bus.write_sel, bus.write_data,
             bus.rs1_pending, bus.rs2_pending};
      exp = {model_ready(0), model_ready(1), m_write, m_wsel, m_wdata,
             model_pending(bus.rs1_sel), model_pending(bus.rs2_sel)};
      vectors++; if (act !== exp) begin
        miscompares++; $display("FAIL random_cycle: cycle %0d got %h expected %h (rdy0,rdy1,w,sel,data,p1,p2)", i, act, exp); end
      advance();
    end
    drive(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 4; i++) advance();
    for (int r = 0; r < 32; r++) begin
      vectors++; if (dut_rf[r] !== m_rf[r]) begin miscompares++; $display("FAIL random_rf: r%0d got %0h expected %0h", r, dut_rf[r], m_rf[r]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; dut_rf[r] = '0; end
    model_reset();
    test_reset();
    test_single();
    test_reg0();
    test_same_reg();
    test_hazard();
    test_contention();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
